// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and default constants for the data-memory responder.
//   - dmem_state_t : status FSM states (RUN, PASS, FAIL)
//   - *_DEF        : default result/scratch addresses and pass value
//   - log_entry_t  : one store-log record, {addr, data}
//   - make_entry   : packs an address/data pair into a log record
package dmem_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2
   } dmem_state_t;

   localparam logic [31:0] RESULT_ADDR_DEF  = 32'd100;
   localparam logic [31:0] SCRATCH_ADDR_DEF = 32'd96;
   localparam logic [31:0] PASS_VALUE_DEF   = 32'd25;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } log_entry_t;

   function automatic log_entry_t make_entry(input logic [31:0] addr,
                                             input logic [31:0] data);
      log_entry_t e;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/store_log_fifo.sv
// store_log_fifo
//   Synchronous FIFO holding recent store records.
//   Ports:
//     clk, reset (sync, active-low)  clock and reset
//     push, push_data                 enqueue request and record
//     pop                             dequeue request (ignored when empty)
//     valid, head                     head-of-queue valid flag and record (zero when empty)
//     overflow                        sticky: a push was dropped because the queue was full
module store_log_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  log_entry_t push_data,
   input  logic       pop,
   output logic       valid,
   output log_entry_t head,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   log_entry_t    mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          overflow_r;

   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;
   logic          drop_s;

   // Occupancy flags and effective push/pop; the extra pointer bit separates full from empty.
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s   = pop && !empty_s;
      // A pop in the same cycle frees the slot, so a push into a full queue still lands.
      push_s  = push && (!full_s || pop_s);
      drop_s  = push && full_s && !pop_s;
   end

   // Record storage; entries are not reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s && reset) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Pointer and sticky overflow update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Head is forced to zero when empty so stale storage never leaks out.
   always_comb begin
      if (empty_s) begin
         head = log_entry_t'(64'd0);
      end else begin
         head = mem_r[rd_ptr_r[AW-1:0]];
      end
      valid    = !empty_s;
      overflow = overflow_r;
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory slave for the single-cycle core: word RAM with combinational
//   read-back, a pass/fail status FSM driven by stores, a saturating store
//   counter and a drainable store log.
//   Optional build macro: DMEM_STRICT_STORE_EN -- when defined, only stores to
//   SCRATCH_ADDR, or PASS_VALUE to RESULT_ADDR, are allowed.
//   Ports:
//     clk, reset (sync, active-low)
//     MemWrite, DataAdr, WriteData  store port from the core
//     ReadData                      combinational load data (0 out of range)
//     done, pass                    sticky run status
//     store_count                   saturating store counter
//     log_valid, log_data, log_ready, log_overflow  store log drain interface
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH        = 64,
   parameter logic [31:0] RESULT_ADDR  = RESULT_ADDR_DEF,
   parameter logic [31:0] SCRATCH_ADDR = SCRATCH_ADDR_DEF,
   parameter logic [31:0] PASS_VALUE   = PASS_VALUE_DEF,
   parameter int          LOG_DEPTH    = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        done,
   output logic        pass,
   output logic [15:0] store_count,
   output logic        log_valid,
   output logic [63:0] log_data,
   input  logic        log_ready,
   output logic        log_overflow
);

   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   logic [31:0]  mem_r [DEPTH];
   dmem_state_t  state_r;
   logic         done_r;
   logic         pass_r;
   logic [15:0]  count_r;

   logic [AW-1:0] index_s;
   logic          in_range_s;
   logic          pass_store_s;
   logic          disallowed_s;
   logic          is_scratch_s;
   log_entry_t    head_s;

   // Address decode and store classification.
   always_comb begin
      index_s      = DataAdr[AW+1:2];
      in_range_s   = (DataAdr < LIMIT);
      is_scratch_s = (DataAdr == SCRATCH_ADDR);
      pass_store_s = (DataAdr == RESULT_ADDR) && (WriteData == PASS_VALUE);
`ifdef DMEM_STRICT_STORE_EN
      disallowed_s = !(is_scratch_s || pass_store_s);
`else
      // The scratch location is always permitted, even if configured out of range.
      disallowed_s = ((DataAdr == RESULT_ADDR) && (WriteData != PASS_VALUE)) ||
                     (!in_range_s && !is_scratch_s);
`endif
   end

   // Combinational load path.
   always_comb begin
      if (in_range_s) begin
         ReadData = mem_r[index_s];
      end else begin
         ReadData = 32'd0;
      end
   end

   // RAM write; deliberately independent of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (MemWrite && in_range_s) begin
         mem_r[index_s] <= WriteData;
      end
   end

   // Status FSM with registered done/pass; PASS and FAIL hold until reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= RUN;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (MemWrite && pass_store_s) begin
                  state_r <= PASS;
                  done_r  <= 1'b1;
                  pass_r  <= 1'b1;
               end else if (MemWrite && disallowed_s) begin
                  state_r <= FAIL;
                  done_r  <= 1'b1;
                  pass_r  <= 1'b0;
               end
            end
            PASS: begin
               done_r <= 1'b1;
               pass_r <= 1'b1;
            end
            FAIL: begin
               done_r <= 1'b1;
               pass_r <= 1'b0;
            end
            default: begin
               // An illegal encoding is treated as a failed run.
               state_r <= FAIL;
               done_r  <= 1'b1;
               pass_r  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating store counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= 16'd0;
      end else if (MemWrite && (count_r != 16'hFFFF)) begin
         count_r <= count_r + 16'd1;
      end
   end

   store_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .clk       (clk),
      .reset     (reset),
      .push      (MemWrite),
      .push_data (make_entry(DataAdr, WriteData)),
      .pop       (log_ready),
      .valid     (log_valid),
      .head      (head_s),
      .overflow  (log_overflow)
   );

   // Output mapping from registered state.
   always_comb begin
      done        = done_r;
      pass        = pass_r;
      store_count = count_r;
      log_data    = head_s;
   end

endmodule
